// File: rtl/vram_burst_fetch_pkg.sv
// Shared definitions for the VRAM burst fetcher: port widths and FSM state encodings.
package vram_burst_fetch_pkg;

    localparam int VRAM_WORD_AW = 15;
    localparam int VRAM_DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The word address space is 15 bits, so the step wraps modulo 2^15.
    function automatic logic [VRAM_WORD_AW-1:0] step_addr(
        input logic [VRAM_WORD_AW-1:0] i_addr,
        input logic [VRAM_WORD_AW-1:0] i_inc
    );
        return i_addr + i_inc;
    endfunction

endpackage

// File: rtl/vram_burst_fetch_fifo.sv
// burst_fifo: first-word fall-through FIFO with a registered occupancy count.
// Clear has priority over push/pop; the head reads as zero when empty.
module burst_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/vram_burst_fetch.sv
// Burst reader for a 32-bit read-only VRAM port feeding a small FWFT FIFO.
// Define VRAM_BURST_FETCH_STRIDE_EN to add an 8-bit address stride captured at start.
module vram_burst_fetch
    import vram_burst_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 9
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [VRAM_WORD_AW-1:0] i_start_addr,
    input  logic [LEN_W-1:0]        i_len,
    input  logic                    i_abort,
`ifdef VRAM_BURST_FETCH_STRIDE_EN
    input  logic [7:0]              i_stride,
`endif
    output logic                    o_busy,
    output logic                    o_done,
    output logic [VRAM_WORD_AW-1:0] o_vram_addr,
    output logic                    o_vram_strobe,
    input  logic                    i_vram_ack,
    input  logic [VRAM_DATA_W-1:0]  i_vram_rddata,
    output logic [VRAM_DATA_W-1:0]  o_out_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [VRAM_WORD_AW-1:0] r_addr_last;
    logic [VRAM_WORD_AW-1:0] w_addr_last_next;
    logic [VRAM_WORD_AW-1:0] w_addr_inc;
    logic [LEN_W-1:0]        r_words_left;
    logic [LEN_W-1:0]        w_words_left_next;
    logic [LEN_W-1:0]        w_words_after_ack;
    logic                    r_done;
    logic                    w_done_next;
    logic                    w_push;
    logic                    w_clear;
    logic [CW-1:0]           w_count;
    logic                    w_empty;
    logic                    w_full;

`ifdef VRAM_BURST_FETCH_STRIDE_EN
    logic [7:0]              r_stride;
    logic                    w_load_stride;
    assign w_addr_inc = VRAM_WORD_AW'(r_stride);
`else
    assign w_addr_inc = VRAM_WORD_AW'(1);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_addr_last  <= '0;
            r_words_left <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_addr_last  <= w_addr_last_next;
            r_words_left <= w_words_left_next;
            r_done       <= w_done_next;
        end
    end

`ifdef VRAM_BURST_FETCH_STRIDE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stride <= '0;
        end else if (w_load_stride) begin
            r_stride <= i_stride;
        end
    end
`endif

    always_comb begin
        w_state_next      = r_state;
        w_addr_last_next  = r_addr_last;
        w_words_left_next = r_words_left;
        w_done_next       = 1'b0;
        w_push            = 1'b0;
        w_clear           = 1'b0;
        o_vram_strobe     = 1'b0;
        o_vram_addr       = r_addr_last;
        w_words_after_ack = r_words_left - LEN_W'(i_vram_ack);
`ifdef VRAM_BURST_FETCH_STRIDE_EN
        w_load_stride     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_abort) begin
                    w_clear = 1'b1;
                end else if (i_start) begin
                    if (i_len == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next      = ST_FETCH;
                        w_addr_last_next  = i_start_addr;
                        w_words_left_next = i_len;
`ifdef VRAM_BURST_FETCH_STRIDE_EN
                        w_load_stride     = 1'b1;
`endif
                    end
                end
            end
            ST_FETCH: begin
                // An ack retires the word at addr_last, so the next request moves on.
                if (i_vram_ack) begin
                    o_vram_addr = step_addr(r_addr_last, w_addr_inc);
                end
                w_addr_last_next = o_vram_addr;
                if (i_abort) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_FLUSH;
                end else begin
                    // Free-space check ignores a same-cycle pop, keeping one request in flight at most.
                    o_vram_strobe = (w_words_after_ack != '0) && !w_full &&
                                    ((w_count + CW'(i_vram_ack)) < CW'(FIFO_DEPTH));
                    if (i_vram_ack) begin
                        w_push            = 1'b1;
                        w_words_left_next = w_words_after_ack;
                        if (w_words_after_ack == '0) begin
                            w_done_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (VRAM_DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_data  (i_vram_rddata),
        .i_pop   (o_out_valid && i_out_ready),
        .o_data  (o_out_data),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_out_valid = !w_empty;

endmodule

// File: tb/tb_vram_burst_fetch.sv
// Self-checking bench for vram_burst_fetch: arbiter/memory model plus burst-level reference.
`timescale 1ns/1ps
module tb_vram_burst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] start_addr = '0;
    logic [8:0]  len = '0;
    logic        abort = 1'b0;
    logic [7:0]  stride = 8'd1;
    logic        busy, done, vram_strobe, out_valid;
    logic [14:0] vram_addr;
    logic        vram_ack = 1'b0;
    logic [31:0] vram_rddata = '0;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int grant_mode = 0;
    int cyc = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    int hold_err = 0;
    bit ready_rand = 1'b0;
    logic        prev_strobe = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [14:0] served_q[$];
    logic [31:0] pop_q[$];

    vram_burst_fetch #(.FIFO_DEPTH(8), .LEN_W(9)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_start_addr  (start_addr),
        .i_len         (len),
        .i_abort       (abort),
`ifdef VRAM_BURST_FETCH_STRIDE_EN
        .i_stride      (stride),
`endif
        .o_busy        (busy),
        .o_done        (done),
        .o_vram_addr   (vram_addr),
        .o_vram_strobe (vram_strobe),
        .i_vram_ack    (vram_ack),
        .i_vram_rddata (vram_rddata),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return {a ^ 15'h2A5C, 2'b01, a};
    endfunction

    function automatic logic [14:0] burst_addr(input logic [14:0] base, input int i, input int s);
        int t;
        t = int'(base) + i * s;
        return t[14:0];
    endfunction

    // Registered-grant VRAM port: a request granted at an edge is acked with data one cycle later.
    always @(posedge clk) begin
        bit g;
        cyc <= cyc + 1;
        case (grant_mode)
            0:       g = 1'b1;
            1:       g = (cyc % 3 == 0);
            default: g = 1'($urandom_range(0, 1));
        endcase
        if (vram_strobe && g) begin
            vram_ack    <= 1'b1;
            vram_rddata <= mem_word(vram_addr);
            served_q.push_back(vram_addr);
        end else begin
            vram_ack    <= 1'b0;
            vram_rddata <= $urandom;
        end
    end

    always @(posedge clk) begin
        if (ready_rand) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (out_valid && out_ready) pop_q.push_back(out_data);
            if (done) done_cnt++;
            if (vram_strobe) strobe_cnt++;
            if (prev_strobe && !vram_ack && vram_strobe && vram_addr != prev_addr) hold_err++;
            prev_strobe = vram_strobe;
            prev_addr   = vram_addr;
        end
    end

    task automatic clr_obs();
        served_q.delete();
        pop_q.delete();
    endtask

    // Start is high in cycle 0; returns 1ns into cycle 1.
    task automatic pulse_start(input logic [14:0] a, input int n, input int s);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; len = 9'(n); stride = 8'(s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_done, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > base_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] got [6];
        string names [6];
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got   = '{32'(busy), 32'(done), 32'(vram_strobe), 32'(vram_addr), 32'(out_valid), out_data};
        names = '{"busy", "done", "strobe", "vram_addr", "out_valid", "out_data"};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_%s: got %0h expected 0", names[i], got[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int base_done;
        grant_mode = 0; out_ready = 1'b1;
        clr_obs();
        base_done = done_cnt;
        pulse_start(15'h0100, 4, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (vram_strobe !== (k <= 4)) begin
                n_fail++;
                $display("FAIL basic_strobe_c%0d: got %b expected %b", k, vram_strobe, (k <= 4));
            end
            if (k <= 4) begin
                n_checks++;
                if (vram_addr !== 15'(15'h0100 + k - 1)) begin
                    n_fail++;
                    $display("FAIL basic_addr_c%0d: got %h expected %h", k, vram_addr, 15'(15'h0100 + k - 1));
                end
            end
            n_checks++;
            if (done !== (k == 6)) begin
                n_fail++;
                $display("FAIL basic_done_c%0d: got %b expected %b", k, done, (k == 6));
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_at_done: got %b expected 0", busy);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (pop_q.size() != 4 || done_cnt != base_done + 1) begin
            n_fail++;
            $display("FAIL basic_counts: got pops %0d dones %0d expected 4 and 1", pop_q.size(), done_cnt - base_done);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pop_q[i] !== mem_word(15'(15'h0100 + i))) begin
                n_fail++;
                $display("FAIL basic_data_%0d: got %h expected %h", i, pop_q[i], mem_word(15'(15'h0100 + i)));
            end
        end
    endtask

    task automatic test_stall();
        logic [14:0] a;
        bit ok;
        int base_done, base_hold;
        grant_mode = 1; out_ready = 1'b1;
        clr_obs();
        a = 15'($urandom);
        base_done = done_cnt; base_hold = hold_err;
        pulse_start(a, 3, 1);
        wait_done(base_done, 60, ok);
        drain(20);
        n_checks++;
        if (!ok || served_q.size() != 3 || pop_q.size() != 3 || done_cnt != base_done + 1) begin
            n_fail++;
            $display("FAIL stall_counts: got done_seen %0b served %0d pops %0d dones %0d expected 1 3 3 1",
                     ok, served_q.size(), pop_q.size(), done_cnt - base_done);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (served_q[i] !== burst_addr(a, i, 1) || pop_q[i] !== mem_word(burst_addr(a, i, 1))) begin
                n_fail++;
                $display("FAIL stall_word_%0d: got addr %h data %h expected addr %h data %h",
                         i, served_q[i], pop_q[i], burst_addr(a, i, 1), mem_word(burst_addr(a, i, 1)));
            end
        end
        n_checks++;
        if (hold_err != base_hold) begin
            n_fail++;
            $display("FAIL stall_addr_hold: got %0d changes expected 0", hold_err - base_hold);
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] a;
        bit ok;
        int base_done;
        grant_mode = 0; out_ready = 1'b0;
        clr_obs();
        a = 15'($urandom);
        base_done = done_cnt;
        pulse_start(a, 12, 1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (vram_strobe !== 1'b0 || served_q.size() != 8 || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: got strobe %b served %0d valid %b busy %b expected 0 8 1 1",
                     vram_strobe, served_q.size(), out_valid, busy);
        end
        n_checks++;
        if (out_data !== mem_word(a)) begin
            n_fail++;
            $display("FAIL bp_head: got %h expected %h", out_data, mem_word(a));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        wait_done(base_done, 40, ok);
        n_checks++;
        if (!ok || served_q.size() != 12 || pop_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_resume: got done_seen %0b served %0d pops %0d expected 1 12 4",
                     ok, served_q.size(), pop_q.size());
        end
        drain(30);
        n_checks++;
        if (pop_q.size() != 12) begin
            n_fail++;
            $display("FAIL bp_total: got %0d words expected 12", pop_q.size());
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (pop_q[i] !== mem_word(burst_addr(a, i, 1))) begin
                n_fail++;
                $display("FAIL bp_data_%0d: got %h expected %h", i, pop_q[i], mem_word(burst_addr(a, i, 1)));
            end
        end
    endtask

    task automatic test_wrap();
        logic [14:0] exp_a [3];
        bit ok;
        int base_done;
        exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000};
        grant_mode = 0; out_ready = 1'b1;
        clr_obs();
        base_done = done_cnt;
        pulse_start(15'h7FFE, 3, 1);
        wait_done(base_done, 30, ok);
        drain(20);
        n_checks++;
        if (!ok || served_q.size() != 3 || pop_q.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_counts: got done_seen %0b served %0d pops %0d expected 1 3 3",
                     ok, served_q.size(), pop_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (served_q[i] !== exp_a[i] || pop_q[i] !== mem_word(exp_a[i])) begin
                n_fail++;
                $display("FAIL wrap_word_%0d: got addr %h data %h expected addr %h data %h",
                         i, served_q[i], pop_q[i], exp_a[i], mem_word(exp_a[i]));
            end
        end
    endtask

    task automatic test_abort();
        logic [14:0] a, b;
        bit ok;
        int base_done;
        grant_mode = 0; out_ready = 1'b0;
        clr_obs();
        a = 15'($urandom); b = 15'($urandom);
        base_done = done_cnt;
        pulse_start(a, 8, 1);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (vram_ack !== 1'b1 || vram_strobe !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_cycle: got ack %b strobe %b valid %b expected 1 0 1", vram_ack, vram_strobe, out_valid);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_flush: got valid %b busy %b expected 0 1", out_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy %b expected 0", busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (done_cnt != base_done || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got dones %0d valid %b expected 0 0", done_cnt - base_done, out_valid);
        end
        clr_obs();
        out_ready = 1'b1;
        base_done = done_cnt;
        pulse_start(b, 3, 1);
        wait_done(base_done, 30, ok);
        drain(20);
        n_checks++;
        if (!ok || pop_q.size() != 3) begin
            n_fail++;
            $display("FAIL abort_restart_counts: got done_seen %0b pops %0d expected 1 3", ok, pop_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (pop_q[i] !== mem_word(burst_addr(b, i, 1))) begin
                n_fail++;
                $display("FAIL abort_restart_%0d: got %h expected %h", i, pop_q[i], mem_word(burst_addr(b, i, 1)));
            end
        end
    endtask

    task automatic test_len_zero();
        int base_done, base_strobe;
        grant_mode = 0; out_ready = 1'b1;
        base_done = done_cnt; base_strobe = strobe_cnt;
        pulse_start(15'($urandom), 0, 1);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || vram_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_cycle1: got done %b busy %b strobe %b expected 1 0 0", done, busy, vram_strobe);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (strobe_cnt != base_strobe || done_cnt != base_done + 1) begin
            n_fail++;
            $display("FAIL len0_totals: got strobes %0d dones %0d expected 0 1",
                     strobe_cnt - base_strobe, done_cnt - base_done);
        end
    endtask

    task automatic test_idle_abort();
        bit ok;
        int base_done, base_strobe;
        grant_mode = 0; out_ready = 1'b0;
        clr_obs();
        base_done = done_cnt;
        pulse_start(15'($urandom), 3, 1);
        wait_done(base_done, 30, ok);
        @(negedge clk);
        n_checks++;
        if (!ok || out_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_abort_pre: got done_seen %0b valid %b busy %b expected 1 1 0", ok, out_valid, busy);
        end
        base_strobe = strobe_cnt;
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1; len = 9'd5;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_abort_clear: got valid %b busy %b expected 0 0", out_valid, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (strobe_cnt != base_strobe) begin
            n_fail++;
            $display("FAIL idle_abort_start_ignored: got %0d strobes expected 0", strobe_cnt - base_strobe);
        end
    endtask

    task automatic test_rst_mid();
        grant_mode = 0; out_ready = 1'b0;
        clr_obs();
        pulse_start(15'($urandom), 10, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (vram_strobe !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || vram_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_after: got strobe %b busy %b valid %b ack %b expected 0 0 0 1",
                     vram_strobe, busy, out_valid, vram_ack);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_late_ack: got valid %b busy %b expected 0 0", out_valid, busy);
        end
    endtask

`ifdef VRAM_BURST_FETCH_STRIDE_EN
    task automatic test_stride();
        logic [14:0] exp_a [5];
        bit ok;
        int base_done;
        exp_a = '{15'h0010, 15'h0014, 15'h0018, 15'h0123, 15'h0123};
        grant_mode = 0; out_ready = 1'b1;
        clr_obs();
        base_done = done_cnt;
        pulse_start(15'h0010, 3, 4);
        wait_done(base_done, 30, ok);
        drain(20);
        base_done = done_cnt;
        pulse_start(15'h0123, 2, 0);
        wait_done(base_done, 30, ok);
        drain(20);
        n_checks++;
        if (served_q.size() != 5 || pop_q.size() != 5) begin
            n_fail++;
            $display("FAIL stride_counts: got served %0d pops %0d expected 5 5", served_q.size(), pop_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (served_q[i] !== exp_a[i] || pop_q[i] !== mem_word(exp_a[i])) begin
                n_fail++;
                $display("FAIL stride_word_%0d: got addr %h data %h expected addr %h data %h",
                         i, served_q[i], pop_q[i], exp_a[i], mem_word(exp_a[i]));
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [14:0] a;
        int n, s, base_done, base_hold, bad;
        bit ok;
        grant_mode = 2;
        base_hold = hold_err;
        for (int it = 0; it < 12; it++) begin
            clr_obs();
            a = 15'($urandom);
            n = $urandom_range(1, 20);
`ifdef VRAM_BURST_FETCH_STRIDE_EN
            s = $urandom_range(0, 255);
`else
            s = 1;
`endif
            base_done = done_cnt;
            ready_rand = 1'b1;
            pulse_start(a, n, s);
            wait_done(base_done, 400, ok);
            ready_rand = 1'b0;
            drain(40);
            bad = -1;
            for (int i = 0; i < n; i++) begin
                if (bad < 0 && (served_q[i] !== burst_addr(a, i, s) || pop_q[i] !== mem_word(burst_addr(a, i, s))))
                    bad = i;
            end
            n_checks++;
            if (!ok || served_q.size() != n || pop_q.size() != n || bad >= 0) begin
                n_fail++;
                $display("FAIL random_burst_%0d: got done_seen %0b served %0d pops %0d first_bad %0d expected 1 %0d %0d -1",
                         it, ok, served_q.size(), pop_q.size(), bad, n, n);
            end
        end
        n_checks++;
        if (hold_err != base_hold) begin
            n_fail++;
            $display("FAIL random_addr_hold: got %0d changes expected 0", hold_err - base_hold);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_wrap();
        test_abort();
        test_len_zero();
        test_idle_abort();
        test_rst_mid();
`ifdef VRAM_BURST_FETCH_STRIDE_EN
        test_stride();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
